// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: level countdown timer, level launch and score judging sequencer
// driving level_fsm and the screen phase mux.
module game_flow_ctrl #(
    parameter int         FRAMES_PER_SEC = 30,
    parameter int         LEVEL_SECONDS  = 60,
    parameter int         NUM_LEVELS     = 4,
    parameter logic [9:0] GOAL_BASE      = 10'd30,
    parameter logic [9:0] GOAL_STEP      = 10'd20
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        is_enter_pressed,
    input  logic        level_ended,
    input  logic [9:0]  level_score,
    output logic        start_level,
    output logic [9:0]  goal,
    output logic        timer_ended,
    output logic [6:0]  seconds_left,
    output logic [2:0]  level_num,
    output logic [11:0] total_score,
    output logic [2:0]  game_state
);
    localparam int FW = $clog2(FRAMES_PER_SEC);

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        LAUNCH    = 3'd1,
        PLAY      = 3'd2,
        WAIT_END  = 3'd3,
        RESULT    = 3'd4,
        GAME_OVER = 3'd5,
        GAME_WON  = 3'd6
    } state_t;

    state_t        state, state_d;
    logic          enter_prev, enter_edge;
    logic [FW-1:0] frame_cnt, frame_d;
    logic [9:0]    goal_d;
    logic          timer_d;
    logic [6:0]    secs_d;
    logic [2:0]    level_d;
    logic [11:0]   total_d;
    logic [12:0]   sum;

    assign game_state = state;

    always_comb begin
        enter_edge = is_enter_pressed & ~enter_prev;
        sum        = {1'b0, total_score} + {3'b0, level_score};
        state_d    = state;
        frame_d    = frame_cnt;
        goal_d     = goal;
        timer_d    = timer_ended;
        secs_d     = seconds_left;
        level_d    = level_num;
        total_d    = total_score;
        case (state)
            TITLE: if (enter_edge) begin
                level_d = 3'd1;
                goal_d  = GOAL_BASE;
                total_d = '0;
                state_d = LAUNCH;
            end
            LAUNCH: state_d = level_ended ? LAUNCH : PLAY;
            PLAY: if (startOfFrame) begin
                if (frame_cnt == FW'(FRAMES_PER_SEC - 1)) begin
                    frame_d = '0;
                    secs_d  = seconds_left - 7'd1;
                    if (seconds_left == 7'd1) begin
                        timer_d = 1'b1;
                        state_d = WAIT_END;
                    end
                end else
                    frame_d = frame_cnt + 1'b1;
            end
            WAIT_END: if (level_ended) begin
                if (level_score >= goal) begin
                    total_d = sum[12] ? 12'hFFF : sum[11:0];
                    state_d = (level_num == 3'(NUM_LEVELS)) ? GAME_WON : RESULT;
                end else
                    state_d = GAME_OVER;
            end
            RESULT: if (enter_edge) begin
                level_d = level_num + 3'd1;
                goal_d  = goal + GOAL_STEP;
                state_d = LAUNCH;
            end
            GAME_OVER: state_d = GAME_OVER;
            GAME_WON: state_d = enter_edge ? TITLE : GAME_WON;
            default: state_d = TITLE;
        endcase
        // Reload the timer on the edge entering LAUNCH so it already reads full there.
        if (state_d == LAUNCH) begin
            secs_d  = 7'(LEVEL_SECONDS);
            frame_d = '0;
            timer_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= TITLE;
            enter_prev   <= 1'b0;
            frame_cnt    <= '0;
            start_level  <= 1'b0;
            goal         <= GOAL_BASE;
            timer_ended  <= 1'b0;
            seconds_left <= 7'(LEVEL_SECONDS);
            level_num    <= 3'd1;
            total_score  <= '0;
        end else begin
            state        <= state_d;
            enter_prev   <= is_enter_pressed;
            frame_cnt    <= frame_d;
            start_level  <= (state_d == LAUNCH);
            goal         <= goal_d;
            timer_ended  <= timer_d;
            seconds_left <= secs_d;
            level_num    <= level_d;
            total_score  <= total_d;
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: randomized scenario bench for game_flow_ctrl against a
// pulse-count based reference model of the game rules.
module tb_game_flow_ctrl;
    localparam int FPS = 30;
    localparam int LS  = 3;
    localparam int NL  = 7;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        is_enter_pressed = 1'b0;
    logic        level_ended = 1'b0;
    logic [9:0]  level_score = '0;
    logic        start_level;
    logic [9:0]  goal;
    logic        timer_ended;
    logic [6:0]  seconds_left;
    logic [2:0]  level_num;
    logic [11:0] total_score;
    logic [2:0]  game_state;

    int n_cmp = 0;
    int n_bad = 0;

    int m_st, m_level, m_goal, m_total, m_pulses;
    bit m_timer, m_prev;

    game_flow_ctrl #(
        .FRAMES_PER_SEC(FPS),
        .LEVEL_SECONDS(LS),
        .NUM_LEVELS(NL),
        .GOAL_BASE(10'd30),
        .GOAL_STEP(10'd20)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .is_enter_pressed(is_enter_pressed),
        .level_ended(level_ended),
        .level_score(level_score),
        .start_level(start_level),
        .goal(goal),
        .timer_ended(timer_ended),
        .seconds_left(seconds_left),
        .level_num(level_num),
        .total_score(total_score),
        .game_state(game_state)
    );

    always #5 clk = ~clk;

    // {game_state, start_level, timer_ended, seconds_left, level_num, goal, total_score}
    wire [36:0] dut_vec = {game_state, start_level, timer_ended, seconds_left, level_num, goal, total_score};

    function automatic logic [36:0] model_vec();
        return {3'(m_st), m_st == 1, m_timer, 7'(LS - m_pulses / FPS), 3'(m_level), 10'(m_goal), 12'(m_total)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_level = 1; m_goal = 30; m_total = 0; m_pulses = 0; m_timer = 0; m_prev = 0;
    endtask

    // Advance the model by the game rules for the current inputs, then one clock.
    task automatic cyc();
        bit e;
        e = is_enter_pressed && !m_prev;
        m_prev = is_enter_pressed;
        case (m_st)
            0: if (e) begin m_level = 1; m_goal = 30; m_total = 0; m_pulses = 0; m_timer = 0; m_st = 1; end
            1: if (!level_ended) m_st = 2;
            2: if (startOfFrame) begin
                m_pulses++;
                if (m_pulses == FPS * LS) begin m_timer = 1; m_st = 3; end
            end
            3: if (level_ended) begin
                if (int'(level_score) >= m_goal) begin
                    m_total = (m_total + int'(level_score) > 4095) ? 4095 : m_total + int'(level_score);
                    m_st = (m_level == NL) ? 6 : 4;
                end else m_st = 5;
            end
            4: if (e) begin m_level++; m_goal = (m_goal + 20) % 1024; m_pulses = 0; m_timer = 0; m_st = 1; end
            6: if (e) m_st = 0;
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        startOfFrame = 0; is_enter_pressed = 0; level_ended = 0; level_score = '0;
        resetN = 0;
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1;
    endtask

    task automatic run_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1;
            cyc();
            startOfFrame = 0;
            repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec !== {3'd0, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0}) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", dut_vec, {3'd0, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0});
        end
    endtask

    task automatic test_launch();
        is_enter_pressed = 1;
        cyc();
        is_enter_pressed = 0;
        n_cmp++;
        if (dut_vec !== {3'd1, 1'b1, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0}) begin
            n_bad++; $display("FAIL launch_enter: got %h want %h", dut_vec, {3'd1, 1'b1, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0});
        end
        cyc();
        n_cmp++;
        if (dut_vec !== {3'd2, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0}) begin
            n_bad++; $display("FAIL launch_play: got %h want %h", dut_vec, {3'd2, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0});
        end
    endtask

    task automatic test_timer();
        for (int i = 0; i < FPS * LS - 1; i++) begin
            startOfFrame = 1;
            cyc();
            startOfFrame = 0;
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL timer_pulse%0d: got %h want %h", i + 1, dut_vec, model_vec());
            end
            repeat ($urandom_range(0, 2)) begin
                is_enter_pressed = 1'($urandom);
                level_ended = 1'($urandom);
                level_score = 10'($urandom);
                cyc();
            end
        end
        is_enter_pressed = 0; level_ended = 0;
        n_cmp++;
        if ({game_state, timer_ended, seconds_left} !== {3'd2, 1'b0, 7'd1}) begin
            n_bad++; $display("FAIL timer_89: got %h want %h", {game_state, timer_ended, seconds_left}, {3'd2, 1'b0, 7'd1});
        end
        startOfFrame = 1;
        cyc();
        startOfFrame = 0;
        n_cmp++;
        if ({game_state, timer_ended, seconds_left} !== {3'd3, 1'b1, 7'd0}) begin
            n_bad++; $display("FAIL timer_90: got %h want %h", {game_state, timer_ended, seconds_left}, {3'd3, 1'b1, 7'd0});
        end
    endtask

    task automatic test_pass();
        level_ended = 1; level_score = 10'd45;
        cyc();
        n_cmp++;
        if (dut_vec !== {3'd4, 1'b0, 1'b1, 7'd0, 3'd1, 10'd30, 12'd45}) begin
            n_bad++; $display("FAIL pass_result: got %h want %h", dut_vec, {3'd4, 1'b0, 1'b1, 7'd0, 3'd1, 10'd30, 12'd45});
        end
        is_enter_pressed = 1;
        cyc();
        is_enter_pressed = 0;
        n_cmp++;
        if (dut_vec !== {3'd1, 1'b1, 1'b0, 7'd3, 3'd2, 10'd50, 12'd45}) begin
            n_bad++; $display("FAIL pass_relaunch1: got %h want %h", dut_vec, {3'd1, 1'b1, 1'b0, 7'd3, 3'd2, 10'd50, 12'd45});
        end
        cyc();
        n_cmp++;
        if (dut_vec !== {3'd1, 1'b1, 1'b0, 7'd3, 3'd2, 10'd50, 12'd45}) begin
            n_bad++; $display("FAIL pass_relaunch2: got %h want %h", dut_vec, {3'd1, 1'b1, 1'b0, 7'd3, 3'd2, 10'd50, 12'd45});
        end
        level_ended = 0;
        cyc();
        n_cmp++;
        if (dut_vec !== {3'd2, 1'b0, 1'b0, 7'd3, 3'd2, 10'd50, 12'd45}) begin
            n_bad++; $display("FAIL pass_play: got %h want %h", dut_vec, {3'd2, 1'b0, 1'b0, 7'd3, 3'd2, 10'd50, 12'd45});
        end
    endtask

    task automatic test_fail();
        run_pulses(FPS * LS);
        level_ended = 1; level_score = 10'd49;
        cyc();
        n_cmp++;
        if (dut_vec !== {3'd5, 1'b0, 1'b1, 7'd0, 3'd2, 10'd50, 12'd45}) begin
            n_bad++; $display("FAIL fail_gameover: got %h want %h", dut_vec, {3'd5, 1'b0, 1'b1, 7'd0, 3'd2, 10'd50, 12'd45});
        end
        for (int i = 0; i < 6; i++) begin
            is_enter_pressed = 1'(i % 2 == 0);
            level_score = 10'($urandom);
            cyc();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL fail_enter_ignored%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        do_reset();
        n_cmp++;
        if (dut_vec !== {3'd0, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0}) begin
            n_bad++; $display("FAIL fail_reset: got %h want %h", dut_vec, {3'd0, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0});
        end
    endtask

    task automatic test_midreset();
        is_enter_pressed = 1;
        cyc();
        is_enter_pressed = 0;
        cyc();
        run_pulses(FPS + 7);
        #2 resetN = 0;
        #1;
        n_cmp++;
        if (dut_vec !== {3'd0, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0}) begin
            n_bad++; $display("FAIL midreset_async: got %h want %h", dut_vec, {3'd0, 1'b0, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0});
        end
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1;
    endtask

    task automatic test_game_won();
        is_enter_pressed = 1;
        cyc();
        is_enter_pressed = 0;
        cyc();
        for (int lv = 1; lv <= NL; lv++) begin
            run_pulses(FPS * LS);
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL won_timeout_l%0d: got %h want %h", lv, dut_vec, model_vec());
            end
            level_ended = 1; level_score = 10'($urandom_range(700, 1023));
            cyc();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL won_judge_l%0d: got %h want %h", lv, dut_vec, model_vec());
            end
            if (lv < NL) begin
                is_enter_pressed = 1;
                cyc();
                is_enter_pressed = 0;
                cyc();
                level_ended = 0;
                cyc();
            end
        end
        n_cmp++;
        if ({game_state, total_score} !== {3'd6, 12'd4095}) begin
            n_bad++; $display("FAIL won_saturate: got %h want %h", {game_state, total_score}, {3'd6, 12'd4095});
        end
        is_enter_pressed = 1;
        cyc();
        level_ended = 0;
        repeat (3) cyc();
        n_cmp++;
        if ({game_state, total_score} !== {3'd0, 12'd4095}) begin
            n_bad++; $display("FAIL won_title_keep: got %h want %h", {game_state, total_score}, {3'd0, 12'd4095});
        end
        is_enter_pressed = 0;
        cyc();
        is_enter_pressed = 1;
        cyc();
        n_cmp++;
        if (dut_vec !== {3'd1, 1'b1, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0}) begin
            n_bad++; $display("FAIL won_relaunch: got %h want %h", dut_vec, {3'd1, 1'b1, 1'b0, 7'd3, 3'd1, 10'd30, 12'd0});
        end
    endtask

    task automatic test_enter_held();
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if ({game_state, start_level} !== {3'd2, 1'b0}) begin
                n_bad++; $display("FAIL enter_held%0d: got %h want %h", i, {game_state, start_level}, {3'd2, 1'b0});
            end
        end
        is_enter_pressed = 0;
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL enter_held_model: got %h want %h", dut_vec, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_timer();
        test_pass();
        test_fail();
        test_midreset();
        test_game_won();
        test_enter_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
